map_walker: RTL and testbench
=============================

MAP_WALKER -- requirements
Module: map_walker

Interface
REQ-001 SHALL have parameter MAP_WIDTH_BITS, default 4, map column index width.
REQ-002 SHALL have parameter MAP_HEIGHT_BITS, default 4, map row index width.
REQ-003 SHALL have parameter DIST_BITS, default 16, unsigned Q8.8 distance width.
REQ-004 SHALL have parameter MAX_STEPS, default 32, step limit before timeout.
REQ-005 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_col / i_row  in  MAP_WIDTH_BITS / MAP_HEIGHT_BITS  start cell.
- i_step_x_neg / i_step_y_neg  in  1  axis direction; 1 = decrement.
- i_side_x / i_side_y  in  DIST_BITS  initial side distances.
- i_delta_x / i_delta_y  in  DIST_BITS  per-step distance increments.
- o_map_col / o_map_row  out  map widths  current cell to map lookup.
- i_map_val  in  1  combinational wall bit for o_map_col/o_map_row.
- o_busy  out  1  walk in progress.
- o_done  out  1  one-cycle completion pulse.
- o_hit_col / o_hit_row  out  map widths  final cell.
- o_hit_side  out  1  0 = last step on X, 1 = on Y.
- o_hit_dist  out  DIST_BITS  wall distance.
- o_timeout  out  1  valid with o_done; 1 = no wall within MAX_STEPS.

Function
REQ-006 SHALL implement states IDLE and WALK; o_busy = (state == WALK).
REQ-007 In IDLE with i_start=1, SHALL latch all start inputs, clear step counter, enter WALK; o_done/o_timeout go 0.
REQ-008 i_start in WALK SHALL be ignored.
REQ-009 Each WALK cycle with step counter > 0 and i_map_val=1 SHALL, at that edge, latch cell into o_hit_col/o_hit_row, pulse o_done, o_timeout=0, enter IDLE, no step taken.
REQ-010 Otherwise each WALK cycle SHALL take one step: if side_x < side_y (strict) step X, else step Y (ties step Y).
REQ-011 A step SHALL move the cell +/-1 on that axis, wrapping modulo 2^width, record that axis's pre-increment side value as dist, set side to side+delta, increment step counter, and set o_hit_side.
REQ-012 Side accumulation SHALL saturate at all-ones of DIST_BITS.
REQ-013 The start cell SHALL never be tested for a wall.
REQ-014 If counter == MAX_STEPS and cell not a wall, SHALL pulse o_done with o_timeout=1, hit outputs = last cell/dist/side, enter IDLE.
REQ-015 Latency: wall at step k SHALL give o_done high in cycle k+2 after the start-sampling cycle (cycle 0).
REQ-016 o_hit_* and o_timeout SHALL hold until next accepted start; o_done SHALL be high exactly one cycle.
REQ-017 o_map_col/o_map_row SHALL always reflect the registered current cell.

Reset
REQ-018 i_reset SHALL force IDLE and zero all outputs and internal registers, taking priority over every other input, including mid-walk.
REQ-019 The cycle after reset release, i_start SHALL be accepted normally.

Structure
REQ-020 Map width/height and DIST_BITS defaults SHALL live in the shared project constants package, reused with map_rom.
REQ-021 One sub-module, map_walker_axis, SHALL hold per-axis side accumulator, saturating add and cell up/down wrap counter; instantiated twice.

Verification
REQ-022 Border-only map stub, start (8,8), X positive, side_x=0x0080, delta_x=0x0100, side_y=delta_y=0xFFFF -> o_done cycle 9, hit (15,8), side 0, dist 0x0680, timeout 0.
REQ-023 Start (1,1), both negative, side_x=side_y=delta_x=delta_y=0x0100 -> tie steps Y, o_done cycle 3, hit (1,0), side 1, dist 0x0100.
REQ-024 All-zero map stub, any start -> o_done cycle 34, o_timeout=1, o_busy low afterwards.
REQ-025 side_x=0xFF80, delta_x=0x0100, side_y=0xFFFF, delta_y=0x0001 -> after first X step side_x=0xFFFF; next step Y (tie); no wrap of accumulators.
REQ-026 i_start pulsed mid-walk -> ignored, result unchanged; i_reset mid-walk -> next cycle o_busy=0, all outputs 0, no o_done.

Source files
------------

// File: rtl/map_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : map_walker_pkg
// Description : Shared project constants for the map subsystem (map
//               geometry and distance width, also used by map_rom) plus
//               the walker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package map_walker_pkg;

    // Map geometry and fixed-point distance width shared with map_rom.
    localparam int unsigned c_map_width_bits  = 4;
    localparam int unsigned c_map_height_bits = 4;
    localparam int unsigned c_dist_bits       = 16;   // unsigned Q8.8
    localparam int unsigned c_max_steps       = 32;

    // Walker control states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_t;

    // Encoding of o_hit_side.
    localparam logic c_side_x = 1'b0;
    localparam logic c_side_y = 1'b1;

endpackage : map_walker_pkg
`default_nettype wire

// File: rtl/map_walker_if.sv
`default_nettype none
// ============================================================================
// Module      : map_walker_if
// Description : Request/result/map-lookup bundle of the grid walker.
//               master : requester that also serves the map lookup
//               slave  : the walker itself
//   i_start, i_col/i_row, i_step_*_neg, i_side_*, i_delta_* : start request
//   o_map_col/o_map_row -> i_map_val                         : wall lookup
//   o_busy, o_done, o_hit_*, o_timeout                       : status/result
// Revision    : 1.0 - initial release
// ============================================================================
interface map_walker_if #(
    parameter int unsigned MAP_WIDTH_BITS  = map_walker_pkg::c_map_width_bits,
    parameter int unsigned MAP_HEIGHT_BITS = map_walker_pkg::c_map_height_bits,
    parameter int unsigned DIST_BITS       = map_walker_pkg::c_dist_bits
) ();
    // Start request
    logic                       i_start;
    logic [MAP_WIDTH_BITS-1:0]  i_col;
    logic [MAP_HEIGHT_BITS-1:0] i_row;
    logic                       i_step_x_neg;
    logic                       i_step_y_neg;
    logic [DIST_BITS-1:0]       i_side_x;
    logic [DIST_BITS-1:0]       i_side_y;
    logic [DIST_BITS-1:0]       i_delta_x;
    logic [DIST_BITS-1:0]       i_delta_y;

    // Map lookup (combinational round trip through the map owner)
    logic [MAP_WIDTH_BITS-1:0]  o_map_col;
    logic [MAP_HEIGHT_BITS-1:0] o_map_row;
    logic                       i_map_val;

    // Status and result
    logic                       o_busy;
    logic                       o_done;
    logic [MAP_WIDTH_BITS-1:0]  o_hit_col;
    logic [MAP_HEIGHT_BITS-1:0] o_hit_row;
    logic                       o_hit_side;
    logic [DIST_BITS-1:0]       o_hit_dist;
    logic                       o_timeout;

    modport master (
        output i_start, i_col, i_row, i_step_x_neg, i_step_y_neg,
               i_side_x, i_side_y, i_delta_x, i_delta_y, i_map_val,
        input  o_map_col, o_map_row, o_busy, o_done,
               o_hit_col, o_hit_row, o_hit_side, o_hit_dist, o_timeout
    );

    modport slave (
        input  i_start, i_col, i_row, i_step_x_neg, i_step_y_neg,
               i_side_x, i_side_y, i_delta_x, i_delta_y, i_map_val,
        output o_map_col, o_map_row, o_busy, o_done,
               o_hit_col, o_hit_row, o_hit_side, o_hit_dist, o_timeout
    );

endinterface : map_walker_if
`default_nettype wire

// File: rtl/map_walker_axis.sv
`default_nettype none
// ============================================================================
// Module      : map_walker_axis
// Description : One axis of the grid walk: side-distance accumulator with
//               saturating add and an up/down cell counter that wraps
//               modulo 2^CELL_BITS.
//   i_load  : capture i_cell/i_side/i_delta/i_neg (start of a walk)
//   i_step  : move cell one place and add delta to side
//   o_cell  : current cell on this axis
//   o_side  : current side distance (value before any pending step)
// Revision    : 1.0 - initial release
// ============================================================================
module map_walker_axis #(
    parameter int unsigned CELL_BITS = map_walker_pkg::c_map_width_bits,
    parameter int unsigned DIST_BITS = map_walker_pkg::c_dist_bits
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_neg,
    input  logic [CELL_BITS-1:0] i_cell,
    input  logic [DIST_BITS-1:0] i_side,
    input  logic [DIST_BITS-1:0] i_delta,
    output logic [CELL_BITS-1:0] o_cell,
    output logic [DIST_BITS-1:0] o_side
);

    logic [CELL_BITS-1:0] r_cell;
    logic [DIST_BITS-1:0] r_side;
    logic [DIST_BITS-1:0] r_delta;
    logic                 r_neg;

    logic [DIST_BITS:0]   w_sum;
    logic [DIST_BITS-1:0] w_side_next;
    logic [CELL_BITS-1:0] w_cell_next;

    always_comb begin
        // One extra bit catches the carry; a carry pins the side at all-ones
        // so a far-away axis can never wrap round to look close again.
        w_sum       = {1'b0, r_side} + {1'b0, r_delta};
        w_side_next = w_sum[DIST_BITS] ? '1 : w_sum[DIST_BITS-1:0];
        w_cell_next = r_neg ? (r_cell - CELL_BITS'(1)) : (r_cell + CELL_BITS'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cell  <= '0;
            r_side  <= '0;
            r_delta <= '0;
            r_neg   <= 1'b0;
        end else if (i_load) begin
            r_cell  <= i_cell;
            r_side  <= i_side;
            r_delta <= i_delta;
            r_neg   <= i_neg;
        end else if (i_step) begin
            r_cell  <= w_cell_next;
            r_side  <= w_side_next;
        end
    end

    assign o_cell = r_cell;
    assign o_side = r_side;

endmodule : map_walker_axis
`default_nettype wire

// File: rtl/map_walker.sv
`default_nettype none
// ============================================================================
// Module      : map_walker
// Description : Grid (DDA) walker. After a start request it steps one cell
//               per cycle along whichever axis has the smaller side distance
//               (ties go to Y) until the map reports a wall or MAX_STEPS
//               steps have been taken, then reports the final cell, the side
//               of the last step and the distance at that step.
//   i_clk, i_reset : clock and synchronous active-high reset
//   bus (slave)    : start request, map lookup, status and result
// Revision    : 1.0 - initial release
// ============================================================================
module map_walker
    import map_walker_pkg::*;
#(
    parameter int unsigned MAP_WIDTH_BITS  = map_walker_pkg::c_map_width_bits,
    parameter int unsigned MAP_HEIGHT_BITS = map_walker_pkg::c_map_height_bits,
    parameter int unsigned DIST_BITS       = map_walker_pkg::c_dist_bits,
    parameter int unsigned MAX_STEPS       = map_walker_pkg::c_max_steps
) (
    input  logic         i_clk,
    input  logic         i_reset,
    map_walker_if.slave  bus
);

    localparam int unsigned         c_cnt_bits = $clog2(MAX_STEPS + 1);
    localparam logic [c_cnt_bits-1:0] c_max_cnt = c_cnt_bits'(MAX_STEPS);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    walk_state_t                r_state;
    logic [c_cnt_bits-1:0]      r_step_cnt;
    logic                       r_done;
    logic                       r_timeout;
    logic [MAP_WIDTH_BITS-1:0]  r_hit_col;
    logic [MAP_HEIGHT_BITS-1:0] r_hit_row;
    logic                       r_hit_side;
    logic [DIST_BITS-1:0]       r_hit_dist;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    walk_state_t                w_state_nxt;
    logic                       w_load;
    logic                       w_step;
    logic                       w_finish;
    logic                       w_timeout_nxt;
    logic                       w_step_x;
    logic                       w_step_y;
    logic                       w_x_closer;
    logic                       w_wall;
    logic [MAP_WIDTH_BITS-1:0]  w_cell_x;
    logic [MAP_HEIGHT_BITS-1:0] w_cell_y;
    logic [DIST_BITS-1:0]       w_side_x;
    logic [DIST_BITS-1:0]       w_side_y;

    // The start cell (counter still zero) is never treated as a wall so a
    // walk that begins inside a wall cell still leaves it.
    assign w_wall     = (r_step_cnt != '0) && bus.i_map_val;
    assign w_x_closer = (w_side_x < w_side_y);

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_finish      = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                // A wall wins over the step limit when both happen together.
                if (w_wall) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_step_cnt == c_max_cnt) begin
                    w_finish      = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_step_x = w_step &&  w_x_closer;
    assign w_step_y = w_step && !w_x_closer;

    // ------------------------------------------------------------------
    // Axis datapaths
    // ------------------------------------------------------------------
    map_walker_axis #(
        .CELL_BITS (MAP_WIDTH_BITS),
        .DIST_BITS (DIST_BITS)
    ) u_axis_x (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_step  (w_step_x),
        .i_neg   (bus.i_step_x_neg),
        .i_cell  (bus.i_col),
        .i_side  (bus.i_side_x),
        .i_delta (bus.i_delta_x),
        .o_cell  (w_cell_x),
        .o_side  (w_side_x)
    );

    map_walker_axis #(
        .CELL_BITS (MAP_HEIGHT_BITS),
        .DIST_BITS (DIST_BITS)
    ) u_axis_y (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_step  (w_step_y),
        .i_neg   (bus.i_step_y_neg),
        .i_cell  (bus.i_row),
        .i_side  (bus.i_side_y),
        .i_delta (bus.i_delta_y),
        .o_cell  (w_cell_y),
        .o_side  (w_side_y)
    );

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hit_col  <= '0;
            r_hit_row  <= '0;
            r_hit_side <= 1'b0;
            r_hit_dist <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;

            if (w_load) begin
                r_step_cnt <= '0;
                r_timeout  <= 1'b0;
            end

            // Distance and side track every step, so on a wall or timeout
            // they already describe the step that reached the final cell.
            if (w_step) begin
                r_step_cnt <= r_step_cnt + c_cnt_bits'(1);
                r_hit_dist <= w_x_closer ? w_side_x : w_side_y;
                r_hit_side <= w_x_closer ? c_side_x : c_side_y;
            end

            if (w_finish) begin
                r_hit_col <= w_cell_x;
                r_hit_row <= w_cell_y;
                r_timeout <= w_timeout_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_map_col  = w_cell_x;
    assign bus.o_map_row  = w_cell_y;
    assign bus.o_busy     = (r_state == ST_WALK);
    assign bus.o_done     = r_done;
    assign bus.o_hit_col  = r_hit_col;
    assign bus.o_hit_row  = r_hit_row;
    assign bus.o_hit_side = r_hit_side;
    assign bus.o_hit_dist = r_hit_dist;
    assign bus.o_timeout  = r_timeout;

endmodule : map_walker
`default_nettype wire

// File: tb/tb_map_walker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_map_walker
// Description : Self-checking bench for map_walker. A walk model computes
//               the expected cell trajectory, completion cycle and result
//               for each directed request; a compare process checks the DUT
//               against it every cycle of the walk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_walker;

    localparam int WB = 4;
    localparam int HB = 4;
    localparam int DB = 16;
    localparam int MS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    map_walker_if #(.MAP_WIDTH_BITS(WB), .MAP_HEIGHT_BITS(HB), .DIST_BITS(DB)) bus ();

    map_walker #(
        .MAP_WIDTH_BITS  (WB),
        .MAP_HEIGHT_BITS (HB),
        .DIST_BITS       (DB),
        .MAX_STEPS       (MS)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Map stub: mode 0 = walls on the border only, mode 1 = no walls.
    int map_mode = 0;
    always_comb begin
        if (map_mode == 0)
            bus.i_map_val = (bus.o_map_col == '0) || (&bus.o_map_col) ||
                            (bus.o_map_row == '0) || (&bus.o_map_row);
        else
            bus.i_map_val = 1'b0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Walk model
    // ------------------------------------------------------------------
    int exp_D, exp_col, exp_row, exp_side, exp_dist, exp_to;
    int path_col [0:63];
    int path_row [0:63];

    task automatic model(input int col, input int row, input int xn, input int yn,
                         input int sx, input int sy, input int dx, input int dy);
        int cc, cr, cnt, lim;
        bit wall;
        lim = (1 << DB) - 1;
        cc = col;
        cr = row;
        exp_D = 0;
        for (int c = 1; c <= MS + 2; c++) begin
            path_col[c] = cc;
            path_row[c] = cr;
            cnt  = c - 1;   // steps already taken when cycle c starts
            wall = (map_mode == 0) &&
                   (cc == 0 || cc == (1 << WB) - 1 || cr == 0 || cr == (1 << HB) - 1);
            if ((cnt > 0 && wall) || cnt == MS) begin
                exp_D   = c + 1;
                exp_col = cc;
                exp_row = cr;
                exp_to  = (cnt > 0 && wall) ? 0 : 1;
                break;
            end
            if (sx < sy) begin
                exp_dist = sx;
                exp_side = 0;
                sx = (sx + dx > lim) ? lim : sx + dx;
                cc = (cc + (xn != 0 ? -1 : 1)) & ((1 << WB) - 1);
            end else begin
                exp_dist = sy;
                exp_side = 1;
                sy = (sy + dy > lim) ? lim : sy + dy;
                cr = (cr + (yn != 0 ? -1 : 1)) & ((1 << HB) - 1);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: cycle 0 is the cycle in which start is sampled.
    // ------------------------------------------------------------------
    int cyc    = 0;
    bit active = 1'b0;

    always @(negedge clk) begin
        if (active && cyc >= 1) begin
            check("busy", bus.o_busy, (cyc < exp_D));
            check("done", bus.o_done, (cyc == exp_D));
            if (cyc < exp_D) begin
                check("map_col", bus.o_map_col, path_col[cyc]);
                check("map_row", bus.o_map_row, path_row[cyc]);
                check("timeout_walk", bus.o_timeout, 0);
            end else begin
                check("hit_col", bus.o_hit_col, exp_col);
                check("hit_row", bus.o_hit_row, exp_row);
                check("hit_side", bus.o_hit_side, exp_side);
                check("hit_dist", bus.o_hit_dist, exp_dist);
                check("timeout", bus.o_timeout, exp_to);
            end
        end
    end

    task automatic zero_check(input string tag);
        check({tag, "_busy"},     bus.o_busy, 0);
        check({tag, "_done"},     bus.o_done, 0);
        check({tag, "_hit_col"},  bus.o_hit_col, 0);
        check({tag, "_hit_row"},  bus.o_hit_row, 0);
        check({tag, "_hit_side"}, bus.o_hit_side, 0);
        check({tag, "_hit_dist"}, bus.o_hit_dist, 0);
        check({tag, "_timeout"},  bus.o_timeout, 0);
        check({tag, "_map_col"},  bus.o_map_col, 0);
        check({tag, "_map_row"},  bus.o_map_row, 0);
    endtask

    // One walk: start is presented in cycle 0; mid_start > 0 re-pulses start
    // (with scrambled inputs) in that walk cycle; start_now skips the wait
    // for the next edge; zero_chk checks all-zero outputs during cycle 0.
    task automatic run(input int col, input int row, input int xn, input int yn,
                       input int sx, input int sy, input int dx, input int dy,
                       input int mid_start, input bit start_now, input bit zero_chk);
        model(col, row, xn, yn, sx, sy, dx, dy);
        if (!start_now) begin
            @(posedge clk); #1;
        end
        bus.i_col        = col[WB-1:0];
        bus.i_row        = row[HB-1:0];
        bus.i_step_x_neg = xn[0];
        bus.i_step_y_neg = yn[0];
        bus.i_side_x     = sx[DB-1:0];
        bus.i_side_y     = sy[DB-1:0];
        bus.i_delta_x    = dx[DB-1:0];
        bus.i_delta_y    = dy[DB-1:0];
        bus.i_start      = 1'b1;
        cyc    = 0;
        active = 1'b1;
        if (zero_chk) begin
            @(negedge clk);
            zero_check("post_reset");
        end
        for (int c = 1; c <= exp_D + 2; c++) begin
            @(posedge clk); #1;
            cyc = c;
            bus.i_start = (c == mid_start);
            if (c == mid_start) begin
                bus.i_col    = ~bus.i_col;
                bus.i_side_x = '0;
                bus.i_side_y = '1;
            end
        end
        active      = 1'b0;
        bus.i_start = 1'b0;
    endtask

    // Start a border-map walk, let it run two steps, then reset mid-walk.
    // Returns in the cycle after reset with reset already released.
    task automatic mid_reset();
        @(posedge clk); #1;
        bus.i_col = 4'd8; bus.i_row = 4'd8;
        bus.i_step_x_neg = 1'b0; bus.i_step_y_neg = 1'b0;
        bus.i_side_x = 16'h0080; bus.i_side_y = 16'hFFFF;
        bus.i_delta_x = 16'h0100; bus.i_delta_y = 16'hFFFF;
        bus.i_start = 1'b1;
        @(posedge clk); #1; bus.i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("mid_busy_before_reset", bus.o_busy, 1);
        check("mid_dist_before_reset", bus.o_hit_dist, 16'h0180);
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_col = '0; bus.i_row = '0;
        bus.i_step_x_neg = 1'b0; bus.i_step_y_neg = 1'b0;
        bus.i_side_x = '0; bus.i_side_y = '0;
        bus.i_delta_x = '0; bus.i_delta_y = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        zero_check("reset");

        // Straight X run to the right border.
        map_mode = 0;
        run(8, 8, 0, 0, 16'h0080, 16'hFFFF, 16'h0100, 16'hFFFF, 0, 1'b0, 1'b0);
        check("x_run_model_cycle", exp_D, 9);
        check("x_run_model_dist", exp_dist, 16'h0680);
        check("x_run_dut_col", bus.o_hit_col, 15);
        check("x_run_dut_row", bus.o_hit_row, 8);
        check("x_run_dut_side", bus.o_hit_side, 0);
        check("x_run_dut_dist", bus.o_hit_dist, 16'h0680);
        check("x_run_dut_timeout", bus.o_timeout, 0);

        // Tie goes to Y; both axes decrementing.
        run(1, 1, 1, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1'b0, 1'b0);
        check("tie_model_cycle", exp_D, 3);
        check("tie_dut_col", bus.o_hit_col, 1);
        check("tie_dut_row", bus.o_hit_row, 0);
        check("tie_dut_side", bus.o_hit_side, 1);
        check("tie_dut_dist", bus.o_hit_dist, 16'h0100);

        // Saturating side accumulators: one X step then Y forever.
        run(8, 8, 0, 0, 16'hFF80, 16'hFFFF, 16'h0100, 16'h0001, 0, 1'b0, 1'b0);
        check("sat_model_cycle", exp_D, 10);
        check("sat_dut_col", bus.o_hit_col, 9);
        check("sat_dut_row", bus.o_hit_row, 15);
        check("sat_dut_side", bus.o_hit_side, 1);
        check("sat_dut_dist", bus.o_hit_dist, 16'hFFFF);

        // Start on a wall cell: must leave it rather than stop at once.
        run(0, 5, 0, 1, 16'h0100, 16'h0300, 16'h0100, 16'h0100, 0, 1'b0, 1'b0);

        // Start re-pulsed mid-walk with scrambled inputs: ignored.
        run(3, 12, 1, 0, 16'h0150, 16'h0090, 16'h0200, 16'h0180, 2, 1'b0, 1'b0);

        // Empty map: timeout after MAX_STEPS, with both axes wrapping.
        map_mode = 1;
        run(0, 0, 1, 1, 16'h0100, 16'h0180, 16'h0100, 16'h0100, 0, 1'b0, 1'b0);
        check("timeout_model_cycle", exp_D, 34);
        check("timeout_model_flag", exp_to, 1);
        check("timeout_dut_flag", bus.o_timeout, 1);
        check("timeout_dut_busy_after", bus.o_busy, 0);

        // Reset mid-walk, then start in the very cycle after reset.
        map_mode = 0;
        mid_reset();
        run(2, 2, 1, 0, 16'h0100, 16'h0200, 16'h0100, 16'h0100, 0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_map_walker
`default_nettype wire
